// File: rtl/gray_code_adder_core_pkg.sv
// Shared Gray-code types and helpers for the Gray-domain adder and its decoders.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    typedef logic [DEFAULT_WIDTH-1:0] gray_t;

    // Zero-extended input keeps the MSB of any narrower result correct after truncation.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_code_adder_core_if.sv
// Operand/result bundle for the Gray-domain adder; master drives operands, slave returns the sum.
interface gray_code_adder_core_if
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             co;

    modport master (
        output in_valid, a, b, ci,
        input  out_valid, sum, co
    );

    modport slave (
        input  in_valid, a, b, ci,
        output out_valid, sum, co
    );
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: prefix XOR running down from the MSB.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        bin            = '0;
        bin[WIDTH-1]   = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end
endmodule

// File: rtl/gray_code_adder_core.sv
// Registered adder with Gray-coded operands and sum, binary carry-in/out, 1-cycle latency.
module gray_code_adder_core
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_code_adder_core_if.slave bus
);
    logic [WIDTH-1:0] w_a_bin;
    logic [WIDTH-1:0] w_b_bin;
    logic [WIDTH:0]   w_total;
    logic [WIDTH-1:0] w_sum_gray;

    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_out_valid;

    gray2bin #(.WIDTH(WIDTH)) u_a_dec (
        .gray (bus.a),
        .bin  (w_a_bin)
    );

    gray2bin #(.WIDTH(WIDTH)) u_b_dec (
        .gray (bus.b),
        .bin  (w_b_bin)
    );

    assign w_total    = {1'b0, w_a_bin} + {1'b0, w_b_bin} + {{WIDTH{1'b0}}, bus.ci};
    assign w_sum_gray = WIDTH'(bin2gray(MAX_WIDTH'(w_total[WIDTH-1:0])));

    // Sum and carry hold while idle; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum <= w_sum_gray;
                r_co  <= w_total[WIDTH];
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.co        = r_co;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_gray_code_adder_core.sv
// Bench for gray_code_adder_core at WIDTH=4: directed table, exhaustive sweep, random run vs model.
module tb_gray_code_adder_core;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    gray_code_adder_core_if #(.WIDTH(W)) bus ();

    gray_code_adder_core #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_sum = '0;
    logic         m_co  = 1'b0;
    logic         m_ov  = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_co;
    } vec_t;

    vec_t vecs[6];

    // Model works on plain integers: decode is XOR of all right shifts of the Gray word.
    function automatic int m_g2b(input int g);
        int r = 0;
        for (int s = 0; s < W; s++) r = r ^ (g >> s);
        return r % (1 << W);
    endfunction

    function automatic int m_b2g(input int n);
        return (n ^ (n >> 1)) % (1 << W);
    endfunction

    task automatic check(input string name, input logic [W-1:0] es, input logic ec, input logic ev);
        n_vec++;
        if (bus.sum !== es || bus.co !== ec || bus.out_valid !== ev) begin
            n_err++;
            $display("FAIL %s: got sum=%b co=%b ov=%b, want sum=%b co=%b ov=%b",
                     name, bus.sum, bus.co, bus.out_valid, es, ec, ev);
        end
    endtask

    task automatic step(input logic rst_v, input logic v, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tci, input string name);
        int t;
        @(negedge clk);
        rst_n       = rst_v;
        bus.in_valid = v;
        bus.a       = ta;
        bus.b       = tb;
        bus.ci      = tci;
        @(posedge clk);
        if (!rst_v) begin
            m_sum = '0;
            m_co  = 1'b0;
            m_ov  = 1'b0;
        end else if (v) begin
            t     = m_g2b(int'(ta)) + m_g2b(int'(tb)) + int'(tci);
            m_sum = W'(m_b2g(t % (1 << W)));
            m_co  = (t >= (1 << W));
            m_ov  = 1'b1;
        end else begin
            m_ov  = 1'b0;
        end
        #1;
        check(name, m_sum, m_co, m_ov);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 4'b0011, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'b1000, 4'b0001, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{4'b1000, 4'b1000, 1'b0, 4'b1001, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
        vecs[4] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1};
        vecs[5] = '{4'b0111, 4'b0101, 1'b0, 4'b1110, 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.ci       = 1'b0;

        // Reset with a live input on two consecutive edges: input must be dropped.
        step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, "reset_edge1");
        check("reset_edge1_const", 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, "reset_edge2");
        check("reset_edge2_const", 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, "post_reset");
        check("post_reset_const", 4'b0011, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, "table_model");
            check($sformatf("table_%0d", i), vecs[i].exp_sum, vecs[i].exp_co, 1'b1);
        end

        // Hold: result from 15+15 must persist while idle.
        step(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, "hold_load");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), "hold_model");
            check($sformatf("hold_%0d", k), 4'b1001, 1'b1, 1'b0);
        end

        for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    step(1'b1, 1'b1, 4'(x), 4'(y), 1'(c), "sweep");

        for (int r = 0; r < 300; r++)
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 1'($urandom), "random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
